// File: rtl/scr1_sp_mem.sv
// Single-port synchronous RAM with byte-lane write enables and one-cycle registered read data.
// Define SCR1_SP_MEM_WRITE_FIRST_EN for write-first same-cycle read/write; default is read-first.
module scr1_sp_mem #(
  parameter int unsigned SCR1_WIDTH = 32,
  parameter int unsigned SCR1_SIZE  = 32'h00010000
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                rena,
  input  logic                                                wena,
  input  logic [SCR1_WIDTH/8-1:0]                             weba,
  input  logic [$clog2(SCR1_SIZE/(SCR1_WIDTH/8))-1:0]         addra,
  input  logic [SCR1_WIDTH-1:0]                               dataa,
  output logic [SCR1_WIDTH-1:0]                               qa
);

  localparam int unsigned NB    = SCR1_WIDTH / 8;
  localparam int unsigned DEPTH = SCR1_SIZE / NB;

  logic [SCR1_WIDTH-1:0] ram_block [DEPTH];
  logic [SCR1_WIDTH-1:0] rd_word;

`ifdef SCR1_SP_MEM_WRITE_FIRST_EN
  logic [SCR1_WIDTH-1:0] merged_word;

  // Post-write view of the addressed word: enabled lanes from dataa, the rest from the array.
  always_comb begin
    merged_word = ram_block[addra];
    for (int i = 0; i < int'(NB); i++) begin
      if (weba[i]) begin
        merged_word[8*i +: 8] = dataa[8*i +: 8];
      end
    end
  end

  assign rd_word = wena ? merged_word : ram_block[addra];
`else
  assign rd_word = ram_block[addra];
`endif

  // Array has no reset so preloaded contents survive rst; accesses are gated while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wena) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (weba[i]) begin
          ram_block[addra][8*i +: 8] <= dataa[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qa <= '0;
    end else if (rena) begin
      qa <= rd_word;
    end
  end

endmodule

// File: tb/tb_scr1_sp_mem.sv
// Directed self-checking bench for scr1_sp_mem at default parameters.
module tb_scr1_sp_mem;

  logic        clk;
  logic        rst;
  logic        rena;
  logic        wena;
  logic [3:0]  weba;
  logic [13:0] addra;
  logic [31:0] dataa;
  logic [31:0] qa;

  int n_checks = 0;
  int n_fail   = 0;

  scr1_sp_mem dut (
    .clk   (clk),
    .rst   (rst),
    .rena  (rena),
    .wena  (wena),
    .weba  (weba),
    .addra (addra),
    .dataa (dataa),
    .qa    (qa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_words [4];
    exp_words[0] = 32'h00000093;
    exp_words[1] = 32'h00112233;
    exp_words[2] = 32'h44556677;
    exp_words[3] = 32'h8899AABB;

    rst   = 1'b1;
    rena  = 1'b0;
    wena  = 1'b0;
    weba  = 4'h0;
    addra = '0;
    dataa = '0;
    for (int i = 0; i < 4; i++) dut.ram_block[i] = exp_words[i];

    repeat (2) cyc();
    chk("reset_qa", qa, 32'h0);

    // Write attempted during reset must be ignored.
    wena = 1'b1; weba = 4'hF; addra = 14'd0; dataa = 32'hFFFFFFFF;
    cyc();
    wena = 1'b0;
    rst  = 1'b0;

    rena = 1'b1; addra = 14'd0;
    cyc();
    chk("preload_after_reset", qa, 32'h00000093);
    rena = 1'b0;

    // qa = DEADBEEF, then async reset mid-cycle.
    wena = 1'b1; weba = 4'hF; addra = 14'd7; dataa = 32'hDEADBEEF;
    cyc();
    wena = 1'b0; rena = 1'b1;
    cyc();
    chk("read_deadbeef", qa, 32'hDEADBEEF);
    rena = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async_reset", qa, 32'h0);
    rena = 1'b1;
    cyc();
    chk("reset_held", qa, 32'h0);
    rena = 1'b0;
    rst  = 1'b0;

    // Full-word write then read.
    wena = 1'b1; weba = 4'hF; addra = 14'd5; dataa = 32'h12345678;
    cyc();
    wena = 1'b0; rena = 1'b1;
    cyc();
    chk("full_word", qa, 32'h12345678);
    rena = 1'b0;

    // Byte lane 2.
    wena = 1'b1; weba = 4'b0100; dataa = 32'hABABABAB;
    cyc();
    wena = 1'b0; rena = 1'b1;
    cyc();
    chk("byte_lane2", qa, 32'h12AB5678);
    rena = 1'b0;

    // Low halfword.
    wena = 1'b1; weba = 4'b0011; dataa = 32'hCDEFCDEF;
    cyc();
    wena = 1'b0; rena = 1'b1;
    cyc();
    chk("halfword_low", qa, 32'h12ABCDEF);
    rena = 1'b0;

    // Hold with rena low while the address moves.
    for (int i = 0; i < 10; i++) begin
      addra = 14'(i);
      cyc();
      chk("hold", qa, 32'h12ABCDEF);
    end

    // Same-cycle read and write on word 5.
    rena = 1'b1; wena = 1'b1; weba = 4'b0001; addra = 14'd5; dataa = 32'h000000FF;
    cyc();
`ifdef SCR1_SP_MEM_WRITE_FIRST_EN
    chk("rw_same_cycle", qa, 32'h12ABCDFF);
`else
    chk("rw_same_cycle", qa, 32'h12ABCDEF);
`endif
    wena = 1'b0;
    cyc();
    chk("rw_followup", qa, 32'h12ABCDFF);

    // Back-to-back stream with a wena=1/weba=0 no-op alongside.
    wena = 1'b1; weba = 4'h0; dataa = 32'h0;
    for (int i = 0; i < 4; i++) begin
      addra = 14'(i);
      cyc();
      chk("stream", qa, exp_words[i]);
    end
    wena = 1'b0; rena = 1'b0;

    // weba is ignored while wena is low.
    weba = 4'hF; addra = 14'd3; dataa = 32'h0;
    cyc();
    weba = 4'h0; rena = 1'b1; addra = 14'd2;
    cyc();
    chk("noop_write_word2", qa, exp_words[2]);
    addra = 14'd3;
    cyc();
    chk("weba_ignored_word3", qa, exp_words[3]);
    rena = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
